// File: rtl/ps2_kbd_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Defining PS2_KEYMAP_EN adds the keypad-digit remap table and helper.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam logic [1:0] ERR_START   = 2'd0;
  localparam logic [1:0] ERR_STOP    = 2'd1;
  localparam logic [1:0] ERR_PARITY  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  localparam int PS2_EVT_W = $bits(ps2_evt_t);

`ifdef PS2_KEYMAP_EN
  // Scan codes of keypad keys 0..9 in digit order; digit n maps to KP_BASE+n.
  localparam logic [7:0] KP_SCAN [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                          8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  localparam logic [7:0] KP_BASE = 8'h10;

  function automatic logic [7:0] ps2_keymap(input logic [7:0] code);
    ps2_keymap = code;
    for (int i = 0; i < 10; i++) begin
      if (code == KP_SCAN[i]) ps2_keymap = KP_BASE + 8'(i);
    end
  endfunction
`endif

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Key-event port: valid/ready handshake; a transfer happens on a cycle with
// evt_valid && evt_ready, and the payload holds steady while valid && !ready.
interface ps2_kbd_rx_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;

  modport master (output evt_valid, evt_code, evt_ext, evt_brk, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_ext, evt_brk, output evt_ready);
endinterface

// File: rtl/ps2_kbd_rx_frame.sv
// PS/2 line conditioning and 11-bit frame capture: synchronisers, clock
// glitch filter, IDLE/RECV/CHECK frame FSM and inter-edge timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_stb,
  output logic [7:0] o_byte,
  output logic       o_err_pulse,
  output logic [1:0] o_err_code,
  output ps2_state_e o_dbg_state
);

  localparam int             FCW      = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [15:0]    TO_LAST  = 16'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [FCW-1:0]         r_flt_cnt;
  logic                   r_flt_clk;
  logic                   r_flt_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;
  logic                   w_timeout;

  ps2_state_e  r_state;
  ps2_state_e  w_next;
  logic [10:0] r_shift;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_timer;

  assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];
  assign w_fall      = r_flt_prev & ~r_flt_clk;
  assign w_timeout   = (r_state == ST_RECV) && !w_fall && (r_timer == TO_LAST);
  assign o_byte      = r_shift[8:1];
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_flt_cnt  <= '0;
      r_flt_clk  <= 1'b1;
      r_flt_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_flt_prev <= r_flt_clk;
      // Filtered clock follows only after FILTER_LEN consecutive differing samples.
      if (w_clk_s == r_flt_clk) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_LAST) begin
        r_flt_clk <= w_clk_s;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall) w_next = ST_RECV;
      ST_RECV: begin
        if (w_fall && (r_bit_cnt == 4'd10)) w_next = ST_CHECK;
        else if (w_timeout)                 w_next = ST_IDLE;
      end
      ST_CHECK: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Frame bits land LSB first: after 11 falls r_shift[0]=start, r_shift[10]=stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_timer   <= '0;
    end else if (w_fall && (r_state != ST_CHECK)) begin
      r_shift   <= {w_dat_s, r_shift[10:1]};
      r_bit_cnt <= (r_state == ST_IDLE) ? 4'd1 : r_bit_cnt + 4'd1;
      r_timer   <= '0;
    end else if (r_state == ST_RECV) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  always_comb begin
    o_byte_stb  = 1'b0;
    o_err_pulse = 1'b0;
    o_err_code  = ERR_START;
    case (r_state)
      ST_RECV: begin
        if (w_timeout) begin
          o_err_pulse = 1'b1;
          o_err_code  = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (r_shift[0]) begin
          o_err_pulse = 1'b1;
          o_err_code  = ERR_START;
        end else if (!r_shift[10]) begin
          o_err_pulse = 1'b1;
          o_err_code  = ERR_STOP;
        end else if (!(^r_shift[9:1])) begin
          o_err_pulse = 1'b1;
          o_err_code  = ERR_PARITY;
        end else begin
          o_byte_stb = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: frame capture, E0/F0 prefix folding, optional
// keypad remap (PS2_KEYMAP_EN) and an event FIFO on a valid/ready port.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DATA,
  ps2_kbd_rx_if.master                evt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        err_pulse,
  output logic [1:0]                  err_code,
  output ps2_state_e                  o_dbg_state
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  logic       w_stb;
  logic [7:0] w_byte;
  logic [7:0] w_code_map;
  logic       w_err;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_frame (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ps2_clk   (PS2_CLK),
    .i_ps2_data  (PS2_DATA),
    .o_byte_stb  (w_stb),
    .o_byte      (w_byte),
    .o_err_pulse (w_err),
    .o_err_code  (err_code),
    .o_dbg_state (o_dbg_state)
  );

  assign err_pulse = w_err;

`ifdef PS2_KEYMAP_EN
  logic r_ext_pend;
  assign w_code_map = r_ext_pend ? w_byte : ps2_keymap(w_byte);
`else
  logic r_ext_pend;
  assign w_code_map = w_byte;
`endif

  logic     r_brk_pend;
  logic     r_push;
  ps2_evt_t r_push_evt;

  // Prefix bytes only arm flags; the next ordinary byte carries them into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_push     <= 1'b0;
      r_push_evt <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_err) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_stb) begin
        if (w_byte == PS2_PFX_EXT) begin
          r_ext_pend <= 1'b1;
        end else if (w_byte == PS2_PFX_BRK) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_push          <= 1'b1;
          r_push_evt.code <= w_code_map;
          r_push_evt.ext  <= r_ext_pend;
          r_push_evt.brk  <= r_brk_pend;
          r_ext_pend      <= 1'b0;
          r_brk_pend      <= 1'b0;
        end
      end
    end
  end

  logic [PS2_EVT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_level;
  logic                 r_overflow;
  logic                 w_valid;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  ps2_evt_t             w_head;

  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == DEPTH_L);
  assign w_pop   = w_valid && evt.evt_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = r_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_push_evt;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_push && !w_wr) r_overflow <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign evt.evt_valid = w_valid;
  assign evt.evt_code  = w_head.code;
  assign evt.evt_ext   = w_head.ext;
  assign evt.evt_brk   = w_head.brk;
  assign fifo_level    = r_level;
  assign overflow      = r_overflow;

endmodule
